// File: rtl/arm_ctrl_pkg.sv
// ============================================================================
// Module   : arm_ctrl_pkg
// Desc     : States, ALU codes, condition codes and mux encodings for the multicycle controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam int c_alu_add = 0;
  localparam int c_alu_sub = 1;
  localparam int c_alu_and = 2;
  localparam int c_alu_orr = 3;
  localparam int c_alu_eor = 4;

  // Data-processing cmd field, instruction bits 24:21
  localparam logic [3:0] c_cmd_and = 4'b0000;
  localparam logic [3:0] c_cmd_eor = 4'b0001;
  localparam logic [3:0] c_cmd_sub = 4'b0010;
  localparam logic [3:0] c_cmd_add = 4'b0100;
  localparam logic [3:0] c_cmd_tst = 4'b1000;
  localparam logic [3:0] c_cmd_cmp = 4'b1010;
  localparam logic [3:0] c_cmd_orr = 4'b1100;

  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_mi = 4'b0100;
  localparam logic [3:0] c_cond_pl = 4'b0101;
  localparam logic [3:0] c_cond_vs = 4'b0110;
  localparam logic [3:0] c_cond_vc = 4'b0111;
  localparam logic [3:0] c_cond_hi = 4'b1000;
  localparam logic [3:0] c_cond_ls = 4'b1001;
  localparam logic [3:0] c_cond_ge = 4'b1010;
  localparam logic [3:0] c_cond_lt = 4'b1011;
  localparam logic [3:0] c_cond_gt = 4'b1100;
  localparam logic [3:0] c_cond_le = 4'b1101;
  localparam logic [3:0] c_cond_al = 4'b1110;

  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_rdata  = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  localparam logic [1:0] c_srcb_reg  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

endpackage

`default_nettype wire

// File: rtl/cond_unit.sv
// ============================================================================
// Module   : cond_unit
// Desc     : Combinational ARM condition check of Cond against registered NZCV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condex
);

  logic w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = i_flags;

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      c_cond_eq: o_condex = w_z;
      c_cond_ne: o_condex = ~w_z;
      c_cond_cs: o_condex = w_c;
      c_cond_cc: o_condex = ~w_c;
      c_cond_mi: o_condex = w_n;
      c_cond_pl: o_condex = ~w_n;
      c_cond_vs: o_condex = w_v;
      c_cond_vc: o_condex = ~w_v;
      c_cond_hi: o_condex = w_c & ~w_z;
      c_cond_ls: o_condex = ~w_c | w_z;
      c_cond_ge: o_condex = (w_n == w_v);
      c_cond_lt: o_condex = (w_n != w_v);
      c_cond_gt: o_condex = ~w_z & (w_n == w_v);
      c_cond_le: o_condex = w_z | (w_n != w_v);
      c_cond_al: o_condex = 1'b1;
      default:   o_condex = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Desc     : Multicycle ARM control FSM with NZCV flags, condition gating and
//            memory-ready stall with bounded wait. DECODER_EXT_OPS_EN adds EOR/CMP/TST.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int ALUCTL_W  = 3,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          Cond,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          ALUFlags,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                RegW,
  output logic                MemW,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                BusErr,
  output logic                Undef
);

`ifdef DECODER_EXT_OPS_EN
  localparam bit c_ext_ops = 1'b1;
`else
  localparam bit c_ext_ops = 1'b0;
`endif

  generate
    if (ALUCTL_W < 2) begin : g_aluctl_w_min
      $error("multicycle_controller: ALUCTL_W must be at least 2");
    end
    if (c_ext_ops && (ALUCTL_W < 3)) begin : g_aluctl_w_ext
      $error("multicycle_controller: extended ops need ALUCTL_W of at least 3");
    end
  endgenerate

  state_t                r_state, w_next;
  logic [TIMEOUT_W-1:0]  r_wait;
  logic [3:0]            r_flags;
  logic                  r_condex_q;
  logic                  w_condex;

  logic                  w_dp_valid, w_dp_cv, w_dp_cmp, w_dp_write, w_flag_upd;
  logic [ALUCTL_W-1:0]   w_dp_alu;
  logic                  w_wait_state, w_timeout;
  logic                  w_pcw, w_regw, w_memw, w_irw, w_undef;

  cond_unit u_cond_unit (
    .i_cond   (Cond),
    .i_flags  (r_flags),
    .o_condex (w_condex)
  );

  always_comb begin
    w_dp_valid = 1'b1;
    w_dp_alu   = ALUCTL_W'(c_alu_add);
    w_dp_cv    = 1'b0;
    w_dp_cmp   = 1'b0;
    case (Funct[4:1])
      c_cmd_add: begin w_dp_alu = ALUCTL_W'(c_alu_add); w_dp_cv = 1'b1; end
      c_cmd_sub: begin w_dp_alu = ALUCTL_W'(c_alu_sub); w_dp_cv = 1'b1; end
      c_cmd_and: w_dp_alu = ALUCTL_W'(c_alu_and);
      c_cmd_orr: w_dp_alu = ALUCTL_W'(c_alu_orr);
      c_cmd_eor: begin w_dp_valid = c_ext_ops; w_dp_alu = ALUCTL_W'(c_alu_eor); end
      c_cmd_cmp: begin
        w_dp_valid = c_ext_ops; w_dp_alu = ALUCTL_W'(c_alu_sub);
        w_dp_cv    = 1'b1;      w_dp_cmp = 1'b1;
      end
      c_cmd_tst: begin
        w_dp_valid = c_ext_ops; w_dp_alu = ALUCTL_W'(c_alu_and); w_dp_cmp = 1'b1;
      end
      default:   w_dp_valid = 1'b0;
    endcase
  end

  assign w_dp_write   = w_dp_valid & ~w_dp_cmp;
  assign w_flag_upd   = w_dp_valid & w_condex & (Funct[0] | w_dp_cmp);
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout    = w_wait_state && !MemReady && (r_wait == '1);

  always_comb begin
    w_next     = r_state;
    w_pcw      = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    w_undef    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = c_srcb_reg;
    ResultSrc  = c_res_aluout;
    ALUControl = ALUCTL_W'(c_alu_add);
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_alu;
        if (MemReady) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_alu;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: begin w_next = S_FETCH; w_undef = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = c_srcb_imm;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = c_res_rdata;
        w_regw    = w_condex;
        w_next    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = w_condex & ~w_timeout;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (r_state == S_EXECI) ? c_srcb_imm : c_srcb_reg;
        ALUControl = w_dp_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        // Uses the condition latched before this instruction's own flag update
        w_regw = r_condex_q & w_dp_write;
        w_pcw  = r_condex_q & w_dp_write & (Rd == 4'hf);
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = c_srcb_imm;
        ResultSrc = c_res_alu;
        w_pcw     = w_condex;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  assign PCWrite = rst_n & w_pcw;
  assign RegW    = rst_n & w_regw;
  assign MemW    = rst_n & w_memw;
  assign IRWrite = rst_n & w_irw;
  assign BusErr  = rst_n & w_timeout;
  assign Undef   = rst_n & w_undef;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait     <= '0;
      r_flags    <= 4'b0000;
      r_condex_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait_state && !MemReady && !w_timeout)
        r_wait <= r_wait + TIMEOUT_W'(1);
      else
        r_wait <= '0;
      if ((r_state == S_EXECR) || (r_state == S_EXECI)) begin
        r_condex_q <= w_condex;
        if (w_flag_upd) begin
          r_flags[3:2] <= ALUFlags[3:2];
          if (w_dp_cv) r_flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire
